value_store_writer: RTL and testbench

Sits directly downstream of the insert front end. Consumes its value-beat stream (pointer, byte length, 512-bit payload) and writes each 64-byte box into the value-memory write port at consecutive addresses starting at the allocated pointer. After the last box of an insert is written, it emits one completion record (pointer, length) so the key/hash stage can commit the entry. Packet framing comes from the length carried in the header beat; the input stream has no tlast.

---
 rtl/value_store_writer.sv | 132 +++++++++++++
 tb/tb_value_store_writer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/value_store_writer.sv
// rtl/value_store_writer.sv - writes insert value beats into value memory, one 64-byte box per address
// Emits a {pointer, length} completion once the last box of an insert has been written.
module value_store_writer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+31:0] s_value_data,
  input  logic                  s_value_valid,
  output logic                  s_value_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [31:0]           m_done_data,
  output logic                  m_done_valid,
  input  logic                  m_done_ready,
  output logic                  err_zero_len,
  output logic                  err_ptr_mismatch,
  output logic [31:0]           boxes_written
);

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [15:0]           base_q, base_d;
  logic [15:0]           len_q, len_d;
  logic [10:0]           rem_q, rem_d;
  logic [10:0]           off_q, off_d;
  logic                  wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  zero_d, mism_d;

  logic [15:0]           beat_ptr;
  logic [15:0]           beat_len;
  logic [DATA_WIDTH-1:0] beat_payload;
  logic [10:0]           box_cnt;
  logic [15:0]           body_addr;
  logic                  accept;

  assign beat_ptr     = s_value_data[DATA_WIDTH+31:DATA_WIDTH+16];
  assign beat_len     = s_value_data[DATA_WIDTH+15:DATA_WIDTH];
  assign beat_payload = s_value_data[DATA_WIDTH-1:0];

  // Round-up to whole boxes without a wide adder; 0xFFFF still yields 1024.
  assign box_cnt   = {1'b0, beat_len[15:6]} + {10'b0, |beat_len[5:0]};
  assign body_addr = base_q + {5'b0, off_q};

  assign s_value_ready = (state_q != ST_DONE);
  assign accept        = s_value_valid && s_value_ready;
  assign m_done_valid  = (state_q == ST_DONE);
  assign m_done_data   = {base_q, len_q};

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    rem_d     = rem_q;
    off_d     = off_q;
    wr_en_d   = 1'b0;
    wr_addr_d = mem_wr_addr;
    wr_data_d = mem_wr_data;
    zero_d    = err_zero_len;
    mism_d    = err_ptr_mismatch;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (beat_len == 16'd0) begin
            zero_d = 1'b1;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_WIDTH'(beat_ptr);
            wr_data_d = beat_payload;
            base_d    = beat_ptr;
            len_d     = beat_len;
            off_d     = 11'd1;
            rem_d     = box_cnt - 11'd1;
            state_d   = (box_cnt == 11'd1) ? ST_DONE : ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (accept) begin
          // A stray body pointer is flagged but never redirects the write.
          if (beat_ptr != base_q) mism_d = 1'b1;
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_WIDTH'(body_addr);
          wr_data_d = beat_payload;
          off_d     = off_q + 11'd1;
          rem_d     = rem_q - 11'd1;
          if (rem_q == 11'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (m_done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      base_q           <= '0;
      len_q            <= '0;
      rem_q            <= '0;
      off_q            <= '0;
      mem_wr_en        <= 1'b0;
      mem_wr_addr      <= '0;
      mem_wr_data      <= '0;
      err_zero_len     <= 1'b0;
      err_ptr_mismatch <= 1'b0;
      boxes_written    <= '0;
    end else begin
      state_q          <= state_d;
      base_q           <= base_d;
      len_q            <= len_d;
      rem_q            <= rem_d;
      off_q            <= off_d;
      mem_wr_en        <= wr_en_d;
      mem_wr_addr      <= wr_addr_d;
      mem_wr_data      <= wr_data_d;
      err_zero_len     <= zero_d;
      err_ptr_mismatch <= mism_d;
      boxes_written    <= boxes_written + {31'b0, wr_en_d};
    end
  end

endmodule

// File: tb/tb_value_store_writer.sv
// tb/tb_value_store_writer.sv - directed and randomized checks of value_store_writer
// Expected writes and completions come from ceil(len/64) box arithmetic kept in the bench.
module tb_value_store_writer;

  logic         clk;
  logic         rst_n;
  logic [543:0] s_value_data;
  logic         s_value_valid;
  logic         s_value_ready;
  logic         mem_wr_en;
  logic [15:0]  mem_wr_addr;
  logic [511:0] mem_wr_data;
  logic [31:0]  m_done_data;
  logic         m_done_valid;
  logic         m_done_ready;
  logic         err_zero_len;
  logic         err_ptr_mismatch;
  logic [31:0]  boxes_written;

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_boxes = 0;
  logic        exp_zero  = 1'b0;
  logic        exp_mism  = 1'b0;

  value_store_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(512)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_value_data     (s_value_data),
    .s_value_valid    (s_value_valid),
    .s_value_ready    (s_value_ready),
    .mem_wr_en        (mem_wr_en),
    .mem_wr_addr      (mem_wr_addr),
    .mem_wr_data      (mem_wr_data),
    .m_done_data      (m_done_data),
    .m_done_valid     (m_done_valid),
    .m_done_ready     (m_done_ready),
    .err_zero_len     (err_zero_len),
    .err_ptr_mismatch (err_ptr_mismatch),
    .boxes_written    (boxes_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_reset_values();
    chk("rst_ready", s_value_ready, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);
    chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_done_valid", m_done_valid, 0);
    chk("rst_done_data", m_done_data, 0);
    chk("rst_err_zero", err_zero_len, 0);
    chk("rst_err_mism", err_ptr_mismatch, 0);
    chk("rst_boxes", boxes_written, 0);
  endtask

  // Present one beat and return just after the edge that accepted it.
  task automatic send_beat(input logic [15:0] ptr, input logic [15:0] len, input logic [511:0] payload);
    int waited = 0;
    s_value_data  = {ptr, len, payload};
    s_value_valid = 1'b1;
    while (!s_value_ready && waited < 20) begin
      step();
      waited++;
    end
    chk("accept_wait", s_value_ready, 1);
    step();
    s_value_valid = 1'b0;
  endtask

  task automatic run_packet(input logic [15:0] ptr, input logic [15:0] len, input logic [15:0] body_ptr);
    int nb;
    logic [511:0] d;
    logic [15:0] a;
    nb = (int'(len) + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      d = rand512();
      send_beat((i == 0) ? ptr : body_ptr, (i == 0) ? len : 16'd0, d);
      exp_boxes++;
      if (i != 0 && body_ptr != ptr) exp_mism = 1'b1;
      a = 16'((int'(ptr) + i) % 65536);
      chk("wr_en", mem_wr_en, 1);
      chk("wr_addr", mem_wr_addr, a);
      chk("wr_data", mem_wr_data, d);
      chk("boxes_written", boxes_written, exp_boxes);
      if (i == nb - 1) begin
        chk("done_valid_last", m_done_valid, 1);
        chk("done_data_last", m_done_data, {ptr, len});
        chk("ready_in_done", s_value_ready, 0);
      end else begin
        chk("done_valid_mid", m_done_valid, 0);
        chk("ready_mid", s_value_ready, 1);
      end
    end
  endtask

  // Hold the completion for 'hold' cycles, then handshake it.
  task automatic finish_packet(input int hold, input logic [15:0] ptr, input logic [15:0] len);
    m_done_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_done_valid", m_done_valid, 1);
      chk("hold_done_data", m_done_data, {ptr, len});
      chk("hold_wr_en", mem_wr_en, 0);
      chk("hold_ready", s_value_ready, 0);
    end
    m_done_ready = 1'b1;
    step();
    chk("post_done_valid", m_done_valid, 0);
    chk("post_wr_en", mem_wr_en, 0);
    chk("post_ready", s_value_ready, 1);
    chk("err_zero", err_zero_len, exp_zero);
    chk("err_mism", err_ptr_mismatch, exp_mism);
  endtask

  initial begin
    logic [15:0] rp, rl;
    int hold;
    rst_n         = 1'b0;
    s_value_data  = '0;
    s_value_valid = 1'b0;
    m_done_ready  = 1'b1;
    step();
    step();
    check_reset_values();
    rst_n = 1'b1;
    step();
    check_reset_values();

    // single box
    run_packet(16'h0010, 16'd40, 16'h0010);
    chk("single_done_word", m_done_data, 32'h0010_0028);
    finish_packet(0, 16'h0010, 16'd40);

    // three boxes back-to-back
    run_packet(16'h0100, 16'd150, 16'h0100);
    finish_packet(0, 16'h0100, 16'd150);

    // address wrap
    run_packet(16'hFFFF, 16'd128, 16'hFFFF);
    finish_packet(0, 16'hFFFF, 16'd128);

    // completion backpressure with next header waiting
    run_packet(16'h0300, 16'd64, 16'h0300);
    s_value_data  = {16'h0400, 16'd64, rand512()};
    s_value_valid = 1'b1;
    finish_packet(5, 16'h0300, 16'd64);
    run_packet(16'h0400, 16'd64, 16'h0400);
    finish_packet(0, 16'h0400, 16'd64);

    // zero-length header is consumed and dropped
    s_value_data  = {16'h0500, 16'd0, rand512()};
    s_value_valid = 1'b1;
    step();
    s_value_valid = 1'b0;
    exp_zero = 1'b1;
    chk("zl_wr_en", mem_wr_en, 0);
    chk("zl_done_valid", m_done_valid, 0);
    chk("zl_err", err_zero_len, 1);
    chk("zl_ready", s_value_ready, 1);
    chk("zl_boxes", boxes_written, exp_boxes);

    // body pointer mismatch still writes at base + offset
    run_packet(16'h0100, 16'd128, 16'h0200);
    chk("mism_flag", err_ptr_mismatch, 1);
    finish_packet(0, 16'h0100, 16'd128);

    // reset after beat 2 of a 4-box packet
    send_beat(16'h0600, 16'd256, rand512());
    send_beat(16'h0600, 16'd0, rand512());
    chk("mid_wr_addr", mem_wr_addr, 16'h0601);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_boxes = 0;
    exp_zero  = 1'b0;
    exp_mism  = 1'b0;
    check_reset_values();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_done_valid", m_done_valid, 0);
      chk("after_rst_wr_en", mem_wr_en, 0);
    end
    run_packet(16'h0700, 16'd64, 16'h0700);
    finish_packet(0, 16'h0700, 16'd64);

    // largest length rounds to 1024 boxes
    run_packet(16'hFE00, 16'hFFFF, 16'hFE00);
    chk("max_boxes", boxes_written, exp_boxes);
    finish_packet(1, 16'hFE00, 16'hFFFF);

    // random packets with random completion stalls
    for (int p = 0; p < 8; p++) begin
      rp   = 16'($urandom_range(0, 65535));
      rl   = 16'($urandom_range(1, 700));
      hold = $urandom_range(0, 3);
      run_packet(rp, rl, rp);
      finish_packet(hold, rp, rl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
